// File: rtl/operand_matrix_bank.sv
// Operand store for the matrix-multiply datapath: one MAX_DIM x MAX_DIM
// matrix (row-major) with byte-strobed writes, bulk clear, a registered
// random-access read port and a valid/ready streaming read engine.
module operand_matrix_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DIM_WIDTH  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
  input  logic                    clear_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    stream_start_i,
  input  logic [DIM_WIDTH-1:0]    stream_dim_i,
  input  logic                    stream_transpose_i,
  output logic                    stream_valid_o,
  output logic [DATA_WIDTH-1:0]   stream_data_o,
  output logic                    stream_last_o,
  input  logic                    stream_ready_i,
  output logic                    busy_o
);

  localparam int DEPTH    = MAX_DIM * MAX_DIM;
  localparam int NUM_BYTE = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  state_t                r_state,     w_state_nxt;
  logic [DIM_WIDTH-1:0]  r_n,         w_n_nxt;
  logic                  r_transpose, w_transpose_nxt;
  logic [DIM_WIDTH-1:0]  r_row,       w_row_nxt;
  logic [DIM_WIDTH-1:0]  r_col,       w_col_nxt;
  logic                  r_valid,     w_valid_nxt;
  logic                  r_last,      w_last_nxt;
  logic                  r_busy,      w_busy_nxt;
  logic [DATA_WIDTH-1:0] r_sdata,     w_sdata_nxt;

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic [DIM_WIDTH-1:0]  w_dim_clamped;
  logic [DIM_WIDTH-1:0]  w_n_m1;
  logic [ADDR_WIDTH-1:0] w_fetch_addr;
  logic                  w_xfer;

  assign w_wr_in_range = (32'(wr_addr_i) < DEPTH);
  assign w_rd_in_range = (32'(rd_addr_i) < DEPTH);
  assign w_dim_clamped = (32'(stream_dim_i) > MAX_DIM) ? DIM_WIDTH'(MAX_DIM) : stream_dim_i;
  assign w_n_m1        = r_n - DIM_WIDTH'(1);
  assign w_xfer        = r_valid && stream_ready_i;

  // Storage: async reset, clear has priority over a same-edge write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en_i && w_wr_in_range) begin
      for (int unsigned b = 0; b < NUM_BYTE; b++) begin
        if (wr_strb_i[b]) r_mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  // Random-access read: registered, returns the pre-edge contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rd_data <= '0;
    else         r_rd_data <= w_rd_in_range ? r_mem[rd_addr_i] : '0;
  end

  // Stream engine state and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_transpose <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_sdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_n         <= w_n_nxt;
      r_transpose <= w_transpose_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_valid     <= w_valid_nxt;
      r_last      <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_sdata     <= w_sdata_nxt;
    end
  end

  // Fetch address of the element selected by the next row/column.
  always_comb begin
    w_fetch_addr = ADDR_WIDTH'(32'(w_row_nxt) * MAX_DIM + 32'(w_col_nxt));
  end

  // Stream next-state: the fetch reads the current memory image, so a
  // write or clear on a transfer edge only shows up from the element after.
  always_comb begin
    w_state_nxt     = r_state;
    w_n_nxt         = r_n;
    w_transpose_nxt = r_transpose;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_valid_nxt     = r_valid;
    w_last_nxt      = r_last;
    w_busy_nxt      = r_busy;
    w_sdata_nxt     = r_sdata;
    unique case (r_state)
      ST_IDLE: begin
        if (stream_start_i && (stream_dim_i != '0)) begin
          w_state_nxt     = ST_RUN;
          w_n_nxt         = w_dim_clamped;
          w_transpose_nxt = stream_transpose_i;
          w_row_nxt       = '0;
          w_col_nxt       = '0;
          w_valid_nxt     = 1'b1;
          w_busy_nxt      = 1'b1;
          w_last_nxt      = (w_dim_clamped == DIM_WIDTH'(1));
          w_sdata_nxt     = r_mem[w_fetch_addr];
        end
      end
      ST_RUN: begin
        if (w_xfer) begin
          if (r_last) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_last_nxt  = 1'b0;
          end else begin
            if (!r_transpose) begin
              if (r_col == w_n_m1) begin
                w_col_nxt = '0;
                w_row_nxt = r_row + DIM_WIDTH'(1);
              end else begin
                w_col_nxt = r_col + DIM_WIDTH'(1);
              end
            end else begin
              if (r_row == w_n_m1) begin
                w_row_nxt = '0;
                w_col_nxt = r_col + DIM_WIDTH'(1);
              end else begin
                w_row_nxt = r_row + DIM_WIDTH'(1);
              end
            end
            w_sdata_nxt = r_mem[w_fetch_addr];
            w_last_nxt  = (w_row_nxt == w_n_m1) && (w_col_nxt == w_n_m1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rd_data_o      = r_rd_data;
  assign stream_valid_o = r_valid;
  assign stream_data_o  = r_sdata;
  assign stream_last_o  = r_last;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_operand_matrix_bank.sv
// Directed self-checking bench for operand_matrix_bank.
module tb_operand_matrix_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        clear;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        start;
  logic [2:0]  dim;
  logic        transpose;
  logic        valid;
  logic [31:0] sdata;
  logic        last;
  logic        ready;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  int exp_row3 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int exp_col2 [4] = '{0, 4, 1, 5};

  operand_matrix_bank #(
    .DATA_WIDTH(32),
    .MAX_DIM(4),
    .ADDR_WIDTH(4),
    .DIM_WIDTH(3)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .wr_en_i           (wr_en),
    .wr_addr_i         (wr_addr),
    .wr_data_i         (wr_data),
    .wr_strb_i         (wr_strb),
    .clear_i           (clear),
    .rd_addr_i         (rd_addr),
    .rd_data_o         (rd_data),
    .stream_start_i    (start),
    .stream_dim_i      (dim),
    .stream_transpose_i(transpose),
    .stream_valid_o    (valid),
    .stream_data_o     (sdata),
    .stream_last_o     (last),
    .stream_ready_i    (ready),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input int offset);
    wr_en   = 1'b1;
    wr_strb = 4'hF;
    for (int i = 0; i < 16; i++) begin
      wr_addr = 4'(i);
      wr_data = 32'(i + offset);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    clear = 1'b0; rd_addr = '0; start = 1'b0; dim = '0; transpose = 1'b0;
    ready = 1'b0;

    // 1. reset state
    #3;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_last",  32'(last),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_rd",    rd_data,    32'd0);
    chk("rst_sdata", sdata,      32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick();
      chk($sformatf("rst_mem%0d", i), rd_data, 32'd0);
    end

    // 2. byte strobes
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hAABBCCDD; wr_strb = 4'hF;
    tick();
    wr_data = 32'h11223344; wr_strb = 4'b0101;
    tick();
    wr_en = 1'b0; rd_addr = 4'd5;
    tick();
    chk("strobe", rd_data, 32'hAA22CC44);

    // 3. row-order stream, N=3, full ready
    fill_mem(0);
    ready = 1'b1; dim = 3'd3; transpose = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("row_valid%0d", k), 32'(valid), 32'd1);
      chk($sformatf("row_data%0d", k),  sdata, 32'(exp_row3[k]));
      chk($sformatf("row_last%0d", k),  32'(last), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("row_busy%0d", k),  32'(busy), 32'd1);
      tick();
    end
    chk("row_end_valid", 32'(valid), 32'd0);
    chk("row_end_busy",  32'(busy),  32'd0);

    // 4. column-order stream, N=2, ready toggling
    ready = 1'b0; dim = 3'd2; transpose = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("col_data%0d", k), sdata, 32'(exp_col2[k]));
      tick();
      chk($sformatf("col_hold%0d", k), sdata, 32'(exp_col2[k]));
      chk($sformatf("col_hvld%0d", k), 32'(valid), 32'd1);
      chk($sformatf("col_last%0d", k), 32'(last), (k == 3) ? 32'd1 : 32'd0);
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    chk("col_end_valid", 32'(valid), 32'd0);
    chk("col_end_busy",  32'(busy),  32'd0);

    // 5a. dim=0 start ignored
    dim = 3'd0; transpose = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dim0_valid", 32'(valid), 32'd0);
    chk("dim0_busy",  32'(busy),  32'd0);
    tick();
    chk("dim0_busy2", 32'(busy),  32'd0);

    // 5b. dim=7 clamps to 4; a start during RUN is ignored
    ready = 1'b1; dim = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        start = 1'b1; dim = 3'd2; transpose = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("clamp_data%0d", k), sdata, 32'(k));
      chk($sformatf("clamp_last%0d", k), 32'(last), (k == 15) ? 32'd1 : 32'd0);
      tick();
    end
    start = 1'b0; transpose = 1'b0;
    chk("clamp_end_valid", 32'(valid), 32'd0);
    chk("clamp_end_busy",  32'(busy),  32'd0);

    // 6a. clear beats a same-cycle write
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; clear = 1'b1;
    tick();
    wr_en = 1'b0; clear = 1'b0; rd_addr = 4'd0;
    tick();
    chk("clr_wr_e0", rd_data, 32'd0);
    rd_addr = 4'd3;
    tick();
    chk("clr_wr_e3", rd_data, 32'd0);

    // 6b. clear mid-stream: element loaded on that edge is read-old
    fill_mem(1);
    ready = 1'b1; dim = 3'd2; transpose = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mclr_d0", sdata, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("mclr_d1", sdata, 32'd2);
    tick();
    chk("mclr_d2", sdata, 32'd0);
    tick();
    chk("mclr_d3", sdata, 32'd0);
    chk("mclr_l3", 32'(last), 32'd1);
    tick();
    chk("mclr_end", 32'(valid), 32'd0);

    // 6c. reset mid-stream aborts immediately, no resumption
    fill_mem(1);
    dim = 3'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mrst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_busy",  32'(busy),  32'd0);
    chk("mrst_sdata", sdata,      32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mrst_after_valid", 32'(valid), 32'd0);
    chk("mrst_after_busy",  32'(busy),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
